// File: rtl/clock_switch_ctrl.sv
`timescale 1ns/1ps
// ============================================================================
// clock_switch_ctrl
//
// Sequencing controller for a two-source glitch-free clock multiplexer. It
// runs on the always-on system clock and owns the multiplexer's select line.
// Switch requests arrive over a valid/ready handshake. The controller checks
// that the target source is alive. After every change of the select line it
// enforces a settle interval and then a dwell interval. When enabled, it also
// fails over on its own once the active source stops toggling.
//
// Parameters
//   SETTLE_CYCLES : cycles sel is held after a change before completion (>=1)
//   MIN_DWELL     : cycles after completion before another switch (>=1)
//   TIMEOUT       : idle cycles before a source is declared dead (>=4)
//   SEL_RESET     : value of sel during and after reset
//
// Ports
//   clk       in  system clock, all state lives in this domain
//   rst_n     in  asynchronous active-low reset
//   src_tog   in  [1:0] divide-by-2 toggles from each source domain (async)
//   auto_fo   in  enable automatic failover
//   req_valid in  switch request valid
//   req_sel   in  requested source
//   req_ready out request accepted when req_valid & req_ready (combinational)
//   sel       out registered select to the multiplexer
//   busy      out high while settling or dwelling
//   done      out one-cycle pulse when a request completes
//   err       out qualifies done, held until the next done
//   fo_evt    out one-cycle pulse when a failover starts
//   alive     out [1:0] per-source liveness
// ============================================================================
module clock_switch_ctrl #(
    parameter int   SETTLE_CYCLES = 8,
    parameter int   MIN_DWELL     = 16,
    parameter int   TIMEOUT       = 64,
    parameter logic SEL_RESET     = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] src_tog,
    input  logic       auto_fo,
    input  logic       req_valid,
    input  logic       req_sel,
    output logic       req_ready,
    output logic       sel,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       fo_evt,
    output logic [1:0] alive
);

    // One counter width serves the settle, dwell and idle counters.
    localparam int MAX_SD = (SETTLE_CYCLES > MIN_DWELL) ? SETTLE_CYCLES : MIN_DWELL;
    localparam int MAX_ALL = (MAX_SD > TIMEOUT) ? MAX_SD : TIMEOUT;
    localparam int CW = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LOAD  = CW'(MIN_DWELL - 1);
    localparam logic [CW-1:0] IDLE_MAX    = CW'(TIMEOUT);
    localparam logic [CW-1:0] IDLE_LAST   = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        STABLE = 2'd0,
        SETTLE = 2'd1,
        DWELL  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          by_fo;

    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    sync3;
    logic [1:0]    tog_edge;
    logic [CW-1:0] idle_cnt [2];

    logic          fo_cond;
    logic          accept;

    // ------------------------------------------------------------------
    // Liveness detection.
    // The toggles are asynchronous to clk. Each one passes through two
    // synchronizer flops. A third flop holds the previous synchronized value
    // so that any transition shows up as a single-cycle edge. Between edges
    // the idle counter climbs and saturates at TIMEOUT. The source is
    // declared dead on the cycle the counter reaches TIMEOUT.
    // ------------------------------------------------------------------
    assign tog_edge = sync2 ^ sync3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= 2'b00;
            sync2       <= 2'b00;
            sync3       <= 2'b00;
            alive       <= 2'b00;
            idle_cnt[0] <= '0;
            idle_cnt[1] <= '0;
        end else begin
            sync1 <= src_tog;
            sync2 <= sync1;
            sync3 <= sync2;
            for (int i = 0; i < 2; i++) begin
                if (tog_edge[i]) begin
                    idle_cnt[i] <= '0;
                    alive[i]    <= 1'b1;
                end else if (idle_cnt[i] != IDLE_MAX) begin
                    idle_cnt[i] <= idle_cnt[i] + 1'b1;
                    if (idle_cnt[i] == IDLE_LAST) begin
                        alive[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Failover takes priority over requests. Ready is withheld on the cycle
    // a failover fires, so a pending request simply waits for the next
    // STABLE period.
    // ------------------------------------------------------------------
    assign fo_cond   = auto_fo & ~alive[sel] & alive[~sel];
    assign req_ready = (state == STABLE) & ~fo_cond;
    assign accept    = req_valid & req_ready;

    // ------------------------------------------------------------------
    // Sequencing FSM.
    // The select line changes only when the FSM leaves STABLE. by_fo records
    // whether the current settle was started by a failover; those settles
    // complete silently, without a done pulse. A target that dies during
    // settle is reported through err. The controller never reverts the
    // switch on its own initiative.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= STABLE;
            cnt    <= '0;
            by_fo  <= 1'b0;
            sel    <= SEL_RESET;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            fo_evt <= 1'b0;
        end else begin
            done   <= 1'b0;
            fo_evt <= 1'b0;
            case (state)
                STABLE: begin
                    if (fo_cond) begin
                        sel    <= ~sel;
                        fo_evt <= 1'b1;
                        by_fo  <= 1'b1;
                        cnt    <= SETTLE_LOAD;
                        busy   <= 1'b1;
                        state  <= SETTLE;
                    end else if (accept) begin
                        if (req_sel == sel) begin
                            done <= 1'b1;
                            err  <= 1'b0;
                        end else if (!alive[req_sel]) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            sel   <= req_sel;
                            by_fo <= 1'b0;
                            cnt   <= SETTLE_LOAD;
                            busy  <= 1'b1;
                            state <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        cnt   <= DWELL_LOAD;
                        state <= DWELL;
                        if (!by_fo) begin
                            done <= 1'b1;
                            err  <= ~alive[sel];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DWELL: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= STABLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= STABLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_switch_ctrl.sv
`timescale 1ns/1ps
// ============================================================================
// tb_clock_switch_ctrl
//
// Self-checking bench for clock_switch_ctrl. The main instance uses the
// default parameters. A second instance with TIMEOUT=4 covers the case where
// the target source dies while the controller is settling. Every accepted
// request on the main instance pushes its expected {err, sel} onto a queue.
// A monitor pops one entry for each done pulse and compares it against the
// outputs.
// ============================================================================
module tb_clock_switch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] src_tog = 2'b00;
    logic [1:0] run_tog = 2'b11;
    logic       auto_fo;
    logic       req_valid;
    logic       req_sel;
    logic       req_ready;
    logic       sel;
    logic       busy;
    logic       done;
    logic       err;
    logic       fo_evt;
    logic [1:0] alive;

    logic [1:0] src_tog_b = 2'b00;
    logic [1:0] run_tog_b = 2'b11;
    logic       req_valid_b;
    logic       req_sel_b;
    logic       req_ready_b;
    logic       sel_b;
    logic       busy_b;
    logic       done_b;
    logic       err_b;
    logic       fo_evt_b;
    logic [1:0] alive_b;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic err;
        logic sel;
    } exp_t;

    exp_t sb_q [$];
    exp_t sb_item;

    clock_switch_ctrl u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_tog   (src_tog),
        .auto_fo   (auto_fo),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .sel       (sel),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .fo_evt    (fo_evt),
        .alive     (alive)
    );

    clock_switch_ctrl #(.TIMEOUT(4)) u_dut_t4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_tog   (src_tog_b),
        .auto_fo   (1'b0),
        .req_valid (req_valid_b),
        .req_sel   (req_sel_b),
        .req_ready (req_ready_b),
        .sel       (sel_b),
        .busy      (busy_b),
        .done      (done_b),
        .err       (err_b),
        .fo_evt    (fo_evt_b),
        .alive     (alive_b)
    );

    // 10 ns system clock.
    always #5 clk = ~clk;

    // Source toggles at clk/6, shifted off the clock edge; each can be stopped.
    always begin
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            if (run_tog[i])   src_tog[i]   = ~src_tog[i];
            if (run_tog_b[i]) src_tog_b[i] = ~src_tog_b[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds req_valid until the DUT is ready, then lets one accept edge pass.
    // waited returns how many edges passed before ready was seen.
    task automatic applyStimulus(input logic rs, input logic exp_err, input logic exp_sel,
                                 input int max_wait, output int waited);
        waited    = 0;
        req_valid = 1'b1;
        req_sel   = rs;
        while (req_ready !== 1'b1 && waited < max_wait) begin
            step();
            waited++;
        end
        if (req_ready !== 1'b1) begin
            checkOutput("req_accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
        end else begin
            sb_q.push_back({exp_err, exp_sel});
            step();
            req_valid = 1'b0;
        end
    endtask

    task automatic waitAlive(input string tag);
        int n = 0;
        while (alive !== 2'b11 && n < 30) begin
            step();
            n++;
        end
        checkOutput(tag, alive, 2'b11);
    endtask

    // Scoreboard monitor: every done pulse on the main instance must match a
    // queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checkOutput("done_unexpected", 32'd1, 32'd0);
            end else begin
                sb_item = sb_q.pop_front();
                checkOutput("sb_err", err, sb_item.err);
                checkOutput("sb_sel", sel, sb_item.sel);
            end
        end
    end

    initial begin
        #200us;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int w;
        int n;
        int fo_count;

        rst_n       = 1'b0;
        auto_fo     = 1'b0;
        req_valid   = 1'b0;
        req_sel     = 1'b0;
        req_valid_b = 1'b0;
        req_sel_b   = 1'b0;

        // Reset state.
        repeat (3) step();
        checkOutput("rst_sel", sel, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_alive", alive, 2'b00);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_fo_evt", fo_evt, 1'b0);
        checkOutput("rst_ready", req_ready, 1'b1);

        // Liveness comes up on both sources.
        rst_n = 1'b1;
        n = 0;
        while (alive !== 2'b11 && n < 20) begin
            step();
            n++;
        end
        checkOutput("alive_within_9", (n <= 9), 1'b1);
        checkOutput("alive_both", alive, 2'b11);

        // Full switch 0 -> 1.
        applyStimulus(1'b1, 1'b0, 1'b1, 5, w);
        checkOutput("sw_sel_new", sel, 1'b1);
        checkOutput("sw_busy", busy, 1'b1);
        checkOutput("sw_ready_low", req_ready, 1'b0);
        repeat (7) step();
        checkOutput("sw_done_early", done, 1'b0);
        step();
        checkOutput("sw_done", done, 1'b1);
        checkOutput("sw_err", err, 1'b0);
        repeat (15) step();
        checkOutput("sw_ready_dwell_end", req_ready, 1'b0);
        step();
        checkOutput("sw_ready_back", req_ready, 1'b1);
        checkOutput("sw_busy_clear", busy, 1'b0);

        // Switch back to 0, then issue a no-op request.
        applyStimulus(1'b0, 1'b0, 1'b0, 5, w);
        repeat (24) step();
        checkOutput("back_ready", req_ready, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 5, w);
        checkOutput("noop_done", done, 1'b1);
        checkOutput("noop_err", err, 1'b0);
        checkOutput("noop_busy", busy, 1'b0);
        checkOutput("noop_ready", req_ready, 1'b1);

        // Request a dead source.
        run_tog[1] = 1'b0;
        repeat (75) step();
        checkOutput("dead_alive", alive, 2'b01);
        applyStimulus(1'b1, 1'b1, 1'b0, 5, w);
        checkOutput("dead_done", done, 1'b1);
        checkOutput("dead_err", err, 1'b1);
        checkOutput("dead_sel", sel, 1'b0);
        checkOutput("dead_busy", busy, 1'b0);
        run_tog[1] = 1'b1;
        waitAlive("alive_src1_back");

        // Automatic failover when source 0 stops.
        auto_fo    = 1'b1;
        run_tog[0] = 1'b0;
        n = 0;
        while (fo_evt !== 1'b1 && n < 120) begin
            step();
            n++;
        end
        checkOutput("fo_seen", fo_evt, 1'b1);
        checkOutput("fo_timing", (n >= 60 && n <= 72), 1'b1);
        checkOutput("fo_sel", sel, 1'b1);
        checkOutput("fo_busy", busy, 1'b1);
        step();
        checkOutput("fo_pulse_one", fo_evt, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 40, w);
        checkOutput("fo_req_wait", w, 23);
        checkOutput("fo_req_done", done, 1'b1);
        auto_fo    = 1'b0;
        run_tog[0] = 1'b1;
        waitAlive("alive_src0_back");

        // Reset during DWELL with sel=1.
        applyStimulus(1'b0, 1'b0, 1'b0, 5, w);
        repeat (24) step();
        applyStimulus(1'b1, 1'b0, 1'b1, 5, w);
        repeat (12) step();
        checkOutput("dwell_busy", busy, 1'b1);
        checkOutput("dwell_sel", sel, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_sel", sel, 1'b0);
        checkOutput("async_rst_busy", busy, 1'b0);
        checkOutput("async_rst_alive", alive, 2'b00);
        repeat (2) step();
        rst_n = 1'b1;
        fo_count = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (fo_evt === 1'b1) fo_count++;
        end
        checkOutput("post_rst_no_fo", fo_count, 0);
        checkOutput("post_rst_sel", sel, 1'b0);

        // Target dies during settle, on the TIMEOUT=4 instance.
        n = 0;
        while (alive_b !== 2'b11 && n < 20) begin
            step();
            n++;
        end
        checkOutput("t4_alive", alive_b, 2'b11);
        checkOutput("t4_ready", req_ready_b, 1'b1);
        req_valid_b  = 1'b1;
        req_sel_b    = 1'b1;
        run_tog_b[1] = 1'b0;
        step();
        req_valid_b = 1'b0;
        checkOutput("t4_sel_new", sel_b, 1'b1);
        n = 0;
        while (done_b !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checkOutput("t4_done_latency", n, 8);
        checkOutput("t4_done", done_b, 1'b1);
        checkOutput("t4_err", err_b, 1'b1);
        checkOutput("t4_sel_kept", sel_b, 1'b1);
        checkOutput("t4_no_fo", fo_evt_b, 1'b0);
        checkOutput("t4_busy", busy_b, 1'b1);

        repeat (2) step();
        checkOutput("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
